// File: rtl/exp3_pkg.sv
// Shared definitions for the exp3 memory-game control unit: state codes
// (also shown on the debug display) and the display width.
package exp3_pkg;

  localparam int DB_ESTADO_W = 4;

  typedef enum logic [DB_ESTADO_W-1:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: one-cycle pulso for each 0->1 transition of sinal.
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic pulso
);

  logic r_sinal_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sinal_q <= 1'b0;
    end else begin
      r_sinal_q <= sinal;
    end
  end

  assign pulso = sinal & ~r_sinal_q;

endmodule

// File: rtl/exp3_unidade_controle.sv
// Moore FSM sequencing the exp3 memory game: start, wait for move, register,
// compare, advance or finish (win / error / idle timeout).
module exp3_unidade_controle
  import exp3_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 3000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic                   jogada,
  input  logic                   igual,
  input  logic                   fimC,
  output logic                   zeraC,
  output logic                   contaC,
  output logic                   zeraR,
  output logic                   registraR,
  output logic                   pronto,
  output logic                   acertou,
  output logic                   errou,
  output logic                   timeout,
  output logic [DB_ESTADO_W-1:0] db_estado
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  estado_t       r_estado;
  estado_t       w_estado_next;
  logic [CW-1:0] r_cnt;
  logic          w_jogada_pulso;

  edge_detector u_edge_jogada (
    .clock (clock),
    .reset (reset),
    .sinal (jogada),
    .pulso (w_jogada_pulso)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= INICIAL;
    end else begin
      r_estado <= w_estado_next;
    end
  end

  // Idle counter only runs while waiting for a move; saturates at the limit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_estado == ESPERA) begin
      if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  always_comb begin
    w_estado_next = INICIAL;
    zeraC         = 1'b0;
    contaC        = 1'b0;
    zeraR         = 1'b0;
    registraR     = 1'b0;
    pronto        = 1'b0;
    acertou       = 1'b0;
    errou         = 1'b0;
    timeout       = 1'b0;
    case (r_estado)
      INICIAL: begin
        w_estado_next = iniciar ? PREPARACAO : INICIAL;
      end
      PREPARACAO: begin
        zeraC         = 1'b1;
        zeraR         = 1'b1;
        w_estado_next = ESPERA;
      end
      ESPERA: begin
        // A move arriving on the last allowed cycle still counts.
        if (w_jogada_pulso) begin
          w_estado_next = REGISTRA;
        end else if (r_cnt == CNT_MAX) begin
          w_estado_next = FIM_TIMEOUT;
        end else begin
          w_estado_next = ESPERA;
        end
      end
      REGISTRA: begin
        registraR     = 1'b1;
        w_estado_next = COMPARACAO;
      end
      COMPARACAO: begin
        if (!igual) begin
          w_estado_next = FIM_ERRO;
        end else if (fimC) begin
          w_estado_next = FIM_ACERTO;
        end else begin
          w_estado_next = PROXIMO;
        end
      end
      PROXIMO: begin
        contaC        = 1'b1;
        w_estado_next = ESPERA;
      end
      FIM_ACERTO: begin
        pronto        = 1'b1;
        acertou       = 1'b1;
        w_estado_next = iniciar ? PREPARACAO : FIM_ACERTO;
      end
      FIM_ERRO: begin
        pronto        = 1'b1;
        errou         = 1'b1;
        w_estado_next = iniciar ? PREPARACAO : FIM_ERRO;
      end
      FIM_TIMEOUT: begin
        pronto        = 1'b1;
        timeout       = 1'b1;
        w_estado_next = iniciar ? PREPARACAO : FIM_TIMEOUT;
      end
      default: begin
        w_estado_next = INICIAL;
      end
    endcase
  end

  assign db_estado = r_estado;

endmodule

// File: tb/tb_exp3_unidade_controle.sv
// Directed bench for the exp3 control unit with a short move timeout.
module tb_exp3_unidade_controle;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       fimC;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registraR;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  int n_pass  = 0;
  int n_total = 0;
  int n_conta = 0;
  int n_reg   = 0;

  exp3_unidade_controle #(.TIMEOUT_CYCLES(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .jogada    (jogada),
    .igual     (igual),
    .fimC      (fimC),
    .zeraC     (zeraC),
    .contaC    (contaC),
    .zeraR     (zeraR),
    .registraR (registraR),
    .pronto    (pronto),
    .acertou   (acertou),
    .errou     (errou),
    .timeout   (timeout),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  // {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
  function automatic logic [7:0] outs();
    return {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are then sampled at the falling edge.
  task automatic step();
    @(negedge clock);
    if (contaC) n_conta++;
    if (registraR) n_reg++;
  endtask

  // One move: jogada rises in espera, then registra, then comparacao.
  task automatic do_move(input logic ig, input logic fc);
    jogada = 1'b1;
    step();
    chk("move_registra", {db_estado, outs()}, {4'h4, 8'b0001_0000});
    jogada = 1'b0;
    igual  = ig;
    fimC   = fc;
    step();
    chk("move_compara", db_estado, 4'h5);
    step();
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    step();
    chk("prep", {db_estado, outs()}, {4'h1, 8'b1010_0000});
    iniciar = 1'b0;
    step();
    chk("espera", {db_estado, outs()}, {4'h2, 8'b0000_0000});
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; fimC = 1'b0;
    step();
    chk("reset", {db_estado, outs()}, 12'h000);
    reset = 1'b1;
    step();
    step();
    chk("idle", {db_estado, outs()}, 12'h000);

    // Full correct game: 16 matches, fimC only on the last.
    start_game();
    n_conta = 0;
    for (int i = 0; i < 16; i++) begin
      do_move(1'b1, i == 15);
      if (i < 15) begin
        chk("proximo", {db_estado, outs()}, {4'h6, 8'b0100_0000});
        step();
      end
    end
    chk("acerto", {db_estado, outs()}, {4'hA, 8'b0000_1100});
    chk("acerto_conta", n_conta, 15);
    step(); step(); step();
    chk("acerto_hold", {db_estado, outs()}, {4'hA, 8'b0000_1100});

    // Error on the 3rd move; iniciar ignored while in espera.
    start_game();
    n_conta = 0;
    iniciar = 1'b1;
    step();
    chk("ignora_inic", db_estado, 4'h2);
    iniciar = 1'b0;
    for (int i = 0; i < 2; i++) begin
      do_move(1'b1, 1'b0);
      chk("proximo_e", db_estado, 4'h6);
      step();
    end
    do_move(1'b0, 1'b0);
    chk("erro", {db_estado, outs()}, {4'hE, 8'b0000_1010});
    chk("erro_conta", n_conta, 2);

    // Held switch yields one move only.
    start_game();
    n_reg = 0;
    igual = 1'b1; fimC = 1'b0;
    jogada = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("held_reg", n_reg, 1);
    chk("held_estado", db_estado, 4'h2);
    jogada = 1'b0;
    step();
    chk("held_low", db_estado, 4'h2);
    jogada = 1'b1;
    step();
    chk("second_move", db_estado, 4'h4);
    chk("held_reg2", n_reg, 2);
    jogada = 1'b0;
    step(); step(); step();
    chk("back_espera", db_estado, 4'h2);

    // Timeout after 8 idle cycles in espera.
    for (int i = 0; i < 7; i++) step();
    chk("pre_timeout", db_estado, 4'h2);
    step();
    chk("timeout", {db_estado, outs()}, {4'hD, 8'b0000_1001});
    step();
    chk("timeout_hold", db_estado, 4'hD);

    // Move on the last allowed cycle beats the timeout.
    start_game();
    for (int i = 0; i < 7; i++) step();
    chk("race_espera", db_estado, 4'h2);
    jogada = 1'b1;
    step();
    chk("race_move", {db_estado, outs()}, {4'h4, 8'b0001_0000});
    jogada = 1'b0;
    igual  = 1'b0;
    step(); step();
    chk("race_erro", db_estado, 4'hE);

    // Asynchronous reset mid-espera.
    start_game();
    #2 reset = 1'b0;
    #1;
    chk("async_reset", {db_estado, outs()}, 12'h000);
    reset = 1'b1;
    step();
    chk("after_reset", db_estado, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
